alien_fleet_controller: RTL and testbench

Sequencer for the alien formation: drives the shared movement controls (direction, period, step width) into every alien instance and collects their edge-hit `movement` flags. Reverses and drops the formation at the playfield edge, and speeds the march up as aliens die. Arbitrates the single alien-shot resource among live aliens in round-robin order. Sits between the alien array and the game top level and bullet logic.

---
 rtl/alien_fleet_controller.sv | 166 ++++++++++++++++
 tb/tb_alien_fleet_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_fleet_controller.sv
// alien_fleet_controller
//   Sequences the alien formation: drives the shared march controls into every
//   alien, reverses and drops the formation when any live alien reaches the
//   playfield edge, shortens the march period as aliens die, and hands the
//   single alien-shot resource to live aliens in round-robin order.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start                pulse; starts or restarts a wave (IDLE/CLEARED only)
//   alive[N]             per-alien alive flags
//   edge_hit[N]          per-alien edge-reached flags (used in MARCH only)
//   shot_busy            alien bullet in flight; blocks grants
//   movement_direction   0 = left, 1 = right
//   movement_frequency   march period in cycles
//   movement_width       step width, 0 freezes the formation
//   drop                 one-cycle pulse, formation steps down
//   armed[N]             one-hot shot grant, one cycle
//   fire                 high with any armed bit
//   wave_cleared         high while the wave is cleared
module alien_fleet_controller #(
  parameter int          NUM_ALIENS    = 16,
  parameter logic [15:0] BASE_PERIOD   = 16'd1000,
  parameter logic [15:0] MIN_PERIOD    = 16'd100,
  parameter logic [15:0] PERIOD_STEP   = 16'd50,
  parameter logic [15:0] STEP_WIDTH    = 16'd4,
  parameter logic [15:0] FIRE_INTERVAL = 16'd2000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_ALIENS-1:0] alive,
  input  logic [NUM_ALIENS-1:0] edge_hit,
  input  logic                  shot_busy,
  output logic                  movement_direction,
  output logic [15:0]           movement_frequency,
  output logic [15:0]           movement_width,
  output logic                  drop,
  output logic [NUM_ALIENS-1:0] armed,
  output logic                  fire,
  output logic                  wave_cleared
);

  localparam int IW = (NUM_ALIENS > 1) ? $clog2(NUM_ALIENS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ALIENS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MARCH, S_REVERSE, S_DROP, S_CLEARED
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_dir;
  logic [15:0]           r_freq, r_width;
  logic                  r_drop, r_fire, r_cleared;
  logic [NUM_ALIENS-1:0] r_armed;
  logic [IW-1:0]         r_ptr;
  logic [15:0]           r_timer;

  logic [15:0]           w_period;
  logic                  w_found;
  logic [IW-1:0]         w_gnt_idx;
  logic                  w_grant;
  logic                  w_start_acc;
  logic                  w_any_alive;

  assign w_any_alive = |alive;

  // Period shrinks with each dead alien; signed 32-bit math so an
  // over-aggressive PERIOD_STEP clamps to the floor instead of wrapping.
  always_comb begin : period_calc
    int live;
    int per;
    live = 0;
    for (int i = 0; i < NUM_ALIENS; i++) live += int'(alive[i]);
    per = int'(BASE_PERIOD) - int'(PERIOD_STEP) * (NUM_ALIENS - live);
    if (per < int'(MIN_PERIOD)) w_period = MIN_PERIOD;
    else                        w_period = per[15:0];
  end

  // Round-robin search: first live alien strictly after the last grantee.
  always_comb begin : rr_search
    int j;
    j         = 0;
    w_found   = 1'b0;
    w_gnt_idx = r_ptr;
    for (int k = 1; k <= NUM_ALIENS; k++) begin
      j = (int'(r_ptr) + k) % NUM_ALIENS;
      if (!w_found && alive[IW'(j)]) begin
        w_found   = 1'b1;
        w_gnt_idx = IW'(j);
      end
    end
  end

  // w_found already implies at least one live alien, so a grant can never
  // fire in the cycle the wave empties.
  assign w_grant = (r_state == S_MARCH) && (r_timer == FIRE_INTERVAL) &&
                   !shot_busy && w_found;

  always_comb begin : next_state
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_MARCH;
      S_MARCH:   if (|(edge_hit & alive)) w_state_nxt = S_REVERSE;
      S_REVERSE: w_state_nxt = S_DROP;
      S_DROP:    w_state_nxt = S_MARCH;
      S_CLEARED: if (start) w_state_nxt = S_MARCH;
      default:   w_state_nxt = S_IDLE;
    endcase
    // An empty formation overrides every other move once a wave has begun.
    if (r_state != S_IDLE && !w_any_alive) w_state_nxt = S_CLEARED;
  end

  // A start only counts if it actually launches the march.
  assign w_start_acc = (w_state_nxt == S_MARCH) &&
                       (r_state == S_IDLE || r_state == S_CLEARED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir     <= 1'b1;
      r_freq    <= BASE_PERIOD;
      r_width   <= '0;
      r_drop    <= 1'b0;
      r_armed   <= '0;
      r_fire    <= 1'b0;
      r_cleared <= 1'b0;
      r_ptr     <= LAST_IDX;
      r_timer   <= '0;
    end else begin
      r_freq    <= w_period;
      r_width   <= (w_state_nxt == S_MARCH) ? STEP_WIDTH : 16'd0;
      r_drop    <= (w_state_nxt == S_DROP);
      r_cleared <= (w_state_nxt == S_CLEARED);
      r_fire    <= w_grant;
      r_armed   <= w_grant ? (NUM_ALIENS'(1) << w_gnt_idx) : '0;

      if (w_start_acc)                   r_dir <= 1'b1;
      else if (w_state_nxt == S_REVERSE) r_dir <= ~r_dir;

      if (w_start_acc)  r_ptr <= LAST_IDX;
      else if (w_grant) r_ptr <= w_gnt_idx;

      // Timer runs only while marching and parks at the interval, so a busy
      // bullet just delays the next grant rather than losing it.
      if (w_start_acc || w_grant)
        r_timer <= '0;
      else if (r_state == S_MARCH && r_timer != FIRE_INTERVAL)
        r_timer <= r_timer + 16'd1;
    end
  end

  assign movement_direction = r_dir;
  assign movement_frequency = r_freq;
  assign movement_width     = r_width;
  assign drop               = r_drop;
  assign armed              = r_armed;
  assign fire               = r_fire;
  assign wave_cleared       = r_cleared;

endmodule

// File: tb/tb_alien_fleet_controller.sv
module tb_alien_fleet_controller;
  localparam int N  = 16;
  localparam int FI = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  alive = '0;
  logic [N-1:0]  edge_hit = '0;
  logic          shot_busy = 1'b0;
  logic          dir, drop, fire, clr;
  logic [15:0]   freq, width;
  logic [N-1:0]  armed;
  logic          d2_dir, d2_drop, d2_fire, d2_clr;
  logic [15:0]   d2_freq, d2_width;
  logic [N-1:0]  d2_armed;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alien_fleet_controller #(.NUM_ALIENS(N), .FIRE_INTERVAL(16'(FI))) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alive(alive), .edge_hit(edge_hit),
    .shot_busy(shot_busy), .movement_direction(dir), .movement_frequency(freq),
    .movement_width(width), .drop(drop), .armed(armed), .fire(fire),
    .wave_cleared(clr));

  // Steeper kill step so the period falls through the floor.
  alien_fleet_controller #(.NUM_ALIENS(N), .PERIOD_STEP(16'd70)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .alive(alive), .edge_hit(edge_hit),
    .shot_busy(shot_busy), .movement_direction(d2_dir), .movement_frequency(d2_freq),
    .movement_width(d2_width), .drop(d2_drop), .armed(d2_armed), .fire(d2_fire),
    .wave_cleared(d2_clr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Wave phase: 0 not started, 1 in wave, 2 wiped out.  Turn counter inside a
  // wave: 0 marching, 1 just reversed, 2 dropping.
  int          m_phase, m_turn, m_timer, m_ptr;
  logic        e_dir, e_drop, e_fire, e_clr;
  logic [15:0] e_freq, e_freq2, e_width;
  logic [N-1:0] e_armed;

  function automatic int period(input logic [N-1:0] al, input int step);
    int p;
    p = 1000 - step * (N - $countones(al));
    return (p < 100) ? 100 : p;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_turn = 0; m_timer = 0; m_ptr = N - 1;
    e_dir = 1; e_freq = 16'd1000; e_freq2 = 16'd1000; e_width = 0;
    e_drop = 0; e_fire = 0; e_clr = 0; e_armed = '0;
  endtask

  task automatic model_step(input logic st, input logic [N-1:0] al,
                            input logic [N-1:0] eh, input logic sb);
    bit marching, grant, started;
    int idx;
    marching = (m_phase == 1 && m_turn == 0);
    grant    = marching && m_timer == FI && !sb && al != 0;
    idx      = -1;
    if (grant)
      for (int k = 1; k <= N; k++)
        if (idx < 0 && al[(m_ptr + k) % N]) idx = (m_ptr + k) % N;
    started = 0;
    if (m_phase != 0 && al == 0) begin
      m_phase = 2; m_turn = 0;
    end else if (m_phase != 1 && st) begin
      m_phase = 1; m_turn = 0; started = 1;
    end else if (m_phase == 1) begin
      if (m_turn == 0 && (eh & al) != 0) begin m_turn = 1; e_dir = ~e_dir; end
      else if (m_turn == 1) m_turn = 2;
      else if (m_turn == 2) m_turn = 0;
    end
    if (started) begin
      m_timer = 0; m_ptr = N - 1; e_dir = 1;
    end else if (grant) begin
      m_timer = 0; m_ptr = idx;
    end else if (marching && m_timer < FI) begin
      m_timer++;
    end
    e_freq  = 16'(period(al, 50));
    e_freq2 = 16'(period(al, 70));
    e_width = (m_phase == 1 && m_turn == 0) ? 16'd4 : 16'd0;
    e_drop  = (m_phase == 1 && m_turn == 2);
    e_clr   = (m_phase == 2);
    e_fire  = grant;
    e_armed = grant ? (N'(1) << idx) : '0;
  endtask

  task automatic model_compare();
    chk("rnd_dir", dir, e_dir);
    chk("rnd_freq", freq, e_freq);
    chk("rnd_freq2", d2_freq, e_freq2);
    chk("rnd_width", width, e_width);
    chk("rnd_drop", drop, e_drop);
    chk("rnd_fire", fire, e_fire);
    chk("rnd_armed", armed, e_armed);
    chk("rnd_cleared", clr, e_clr);
  endtask

  // Waits for the next grant, counting cycles; armed must track fire.
  task automatic wait_fire(output int n);
    n = 0;
    do begin
      tick();
      n++;
      chk("fire_eq_armed", fire, |armed);
      chk("armed_onehot", ($countones(armed) <= 1), 1);
    end while (!fire && n < 200);
    if (!fire) chk("grant_timeout", 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dir"}, dir, 1);
    chk({tag, "_freq"}, freq, 1000);
    chk({tag, "_freq2"}, d2_freq, 1000);
    chk({tag, "_width"}, width, 0);
    chk({tag, "_drop"}, drop, 0);
    chk({tag, "_armed"}, armed, 0);
    chk({tag, "_fire"}, fire, 0);
    chk({tag, "_cleared"}, clr, 0);
  endtask

  typedef struct {
    logic [N-1:0] al;
    logic [15:0]  f1;
    logic [15:0]  f2;
  } vec_t;

  initial begin
    vec_t vt[6];
    int   n, fires;
    vt[0] = '{16'hFFFF, 16'd1000, 16'd1000};
    vt[1] = '{16'hFFF0, 16'd800,  16'd720};
    vt[2] = '{16'h00FF, 16'd600,  16'd440};
    vt[3] = '{16'h0F00, 16'd400,  16'd160};
    vt[4] = '{16'h0001, 16'd250,  16'd100};
    vt[5] = '{16'h0000, 16'd200,  16'd100};

    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Period table, exercised in IDLE where the period still tracks alive.
    for (int i = 0; i < 6; i++) begin
      alive = vt[i].al;
      tick();
      chk("tbl_freq", freq, vt[i].f1);
      chk("tbl_freq_floor", d2_freq, vt[i].f2);
      chk("tbl_idle_width", width, 0);
    end

    // Start.
    alive = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_freq", freq, 1000);
    chk("start_dir", dir, 1);
    chk("start_width", width, 4);
    chk("start_drop", drop, 0);
    chk("start_cleared", clr, 0);

    // Edge reversal from a live alien.
    edge_hit = 16'h0020;
    tick();
    edge_hit = '0;
    chk("rev_dir", dir, 0);
    chk("rev_width", width, 0);
    chk("rev_drop", drop, 0);
    tick();
    chk("drop_pulse", drop, 1);
    chk("drop_width", width, 0);
    tick();
    chk("drop_end", drop, 0);
    chk("remarch_width", width, 4);
    tick();
    chk("drop_once", drop, 0);

    // Dead alien at the edge is ignored.
    alive = 16'hFFDF; edge_hit = 16'h0020;
    tick();
    chk("dead_edge_width", width, 4);
    chk("dead_edge_dir", dir, 0);
    tick();
    edge_hit = '0;
    chk("dead_edge_drop", drop, 0);
    chk("dead_edge_freq", freq, 950);

    // Start mid-wave is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored_dir", dir, 0);

    // Wipe out the wave.
    alive = '0;
    tick();
    chk("clr_flag", clr, 1);
    chk("clr_width", width, 0);
    chk("clr_fire", fire, 0);
    chk("clr_armed", armed, 0);
    tick();
    chk("clr_hold", clr, 1);

    // Restart; round-robin over aliens 0 and 2.
    alive = 16'h0005; start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_dir", dir, 1);
    chk("restart_width", width, 4);
    chk("restart_cleared", clr, 0);
    wait_fire(n);
    chk("rr1_gap", n, FI + 1);
    chk("rr1_armed", armed, 16'h0001);
    wait_fire(n);
    chk("rr2_gap", n, FI + 1);
    chk("rr2_armed", armed, 16'h0004);
    wait_fire(n);
    chk("rr3_gap", n, FI + 1);
    chk("rr3_armed", armed, 16'h0001);

    // Busy across expiry holds the grant until the bullet lands.
    shot_busy = 1'b1;
    fires = 0;
    for (int i = 0; i < 3 * FI; i++) begin
      tick();
      if (fire) fires++;
    end
    chk("busy_no_grant", fires, 0);
    shot_busy = 1'b0;
    tick();
    chk("busy_release_fire", fire, 1);
    chk("busy_release_armed", armed, 16'h0004);
    tick();
    chk("busy_release_single", fire, 0);

    // Randomized run against the reference model.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    alive = 16'hFFFF; edge_hit = '0; shot_busy = 1'b0; start = 1'b0;
    model_compare();
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) alive = alive & ~(N'(1) << $urandom_range(0, N - 1));
      if ($urandom_range(0, 299) == 0) alive = '0;
      if ($urandom_range(0, 149) == 0) alive = N'($urandom);
      if (alive == 0 && $urandom_range(0, 9) == 0) alive = N'($urandom) | 16'h0100;
      edge_hit = ($urandom_range(0, 14) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
      if ($urandom_range(0, 9) == 0) shot_busy = ~shot_busy;
      model_step(start, alive, edge_hit, shot_busy);
      tick();
      model_compare();
    end

    // Asynchronous reset mid-run.
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
